// File: rtl/bcd_chain_ctrl_if.sv
// Command and digit-readback bundle between button logic, the BCD chain
// sequencer (slave) and whoever drives commands / owns the digit counters (master).
interface bcd_chain_ctrl_if #(
   parameter int NUM_DIGITS = 2
);
   logic                    start;
   logic                    stop;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] digit_cnt;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    digit_rst;
   logic                    tick;
   logic                    running;
   logic                    overflow;

   modport master (
      output start, stop, clear, digit_cnt,
      input  digit_en, digit_rst, tick, running, overflow
   );

   modport slave (
      input  start, stop, clear, digit_cnt,
      output digit_en, digit_rst, tick, running, overflow
   );
endinterface

// File: rtl/bcd_chain_ctrl.sv
// Run/stop/clear sequencer for a chain of counter_0_to_9 decades: prescaled tick,
// ripple-carry digit enables, chain clear and overflow. Optional BCD_CHAIN_CTRL_SATURATE_EN.
module bcd_chain_ctrl #(
   parameter int NUM_DIGITS = 2,
   parameter int PRESCALE   = 10
) (
   input logic             clk,
   input logic             rst,
   bcd_chain_ctrl_if.slave bus
);
   // state    | meaning
   // ST_IDLE  | digits held at 0, prescaler reloaded
   // ST_RUN   | prescaler counting, digits advance on tick
   // ST_PAUSE | prescaler and digits frozen
   // ST_CLR   | one cycle with digit_rst low
   // ST_SAT   | chain held at all 9s (saturate build only)
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_CLR   = 3'd3,
      ST_SAT   = 3'd4
   } state_t;

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);

   state_t                state;
   logic [PW-1:0]         presc;
   logic                  tick_q;
   logic                  running_q;
   logic                  carry;
   logic                  rollover;
   logic [NUM_DIGITS-1:0] en_raw;

   // Down-counter: reload value corresponds to prescale phase 0, terminal count 0 ends the period.
   always_comb begin
      carry  = tick_q && (state == ST_RUN);
      en_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         en_raw[i] = carry;
         carry     = carry && (bus.digit_cnt[4*i +: 4] == 4'd9);
      end
      rollover = carry;
   end

`ifdef BCD_CHAIN_CTRL_SATURATE_EN
   logic sat_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         presc     <= PRESC_TOP;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
`ifdef BCD_CHAIN_CTRL_SATURATE_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         tick_q <= 1'b0;
         if (bus.clear) begin
            state     <= ST_CLR;
            presc     <= PRESC_TOP;
            running_q <= 1'b0;
`ifdef BCD_CHAIN_CTRL_SATURATE_EN
            sat_q     <= 1'b0;
`endif
         end else begin
            case (state)
               ST_IDLE, ST_PAUSE: begin
                  if (bus.start && !bus.stop) begin
                     state     <= ST_RUN;
                     running_q <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (bus.stop) begin
                     state     <= ST_PAUSE;
                     running_q <= 1'b0;
                  end
`ifdef BCD_CHAIN_CTRL_SATURATE_EN
                  else if (rollover) begin
                     state     <= ST_SAT;
                     running_q <= 1'b0;
                     sat_q     <= 1'b1;
                  end
`endif
                  else if (presc == '0) begin
                     presc  <= PRESC_TOP;
                     tick_q <= 1'b1;
                  end else begin
                     presc <= presc - PW'(1);
                  end
               end
               ST_CLR:  state <= ST_IDLE;
               ST_SAT:  state <= ST_SAT;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.tick      = tick_q;
   assign bus.running   = running_q;
   assign bus.digit_rst = rst && (state != ST_CLR);

`ifdef BCD_CHAIN_CTRL_SATURATE_EN
   // A rolling tick is swallowed so the chain stays at all 9s.
   assign bus.digit_en = rollover ? '0 : en_raw;
   assign bus.overflow = sat_q;
`else
   assign bus.digit_en = en_raw;
   assign bus.overflow = rollover;
`endif
endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Randomized bench for bcd_chain_ctrl with an emulated digit chain and an
// arithmetic reference model (chain value kept as a plain integer count).
`timescale 1ns/1ps
module tb_bcd_chain_ctrl;
   localparam int N    = 2;
   localparam int P    = 4;
   localparam int MAXV = 10**N - 1;
`ifdef BCD_CHAIN_CTRL_SATURATE_EN
   localparam bit SAT_MODE = 1'b1;
`else
   localparam bit SAT_MODE = 1'b0;
`endif

   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_CLR, M_SAT} mmode_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bcd_chain_ctrl_if #(.NUM_DIGITS(N)) bus();

   bcd_chain_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Emulated counter_0_to_9 chain
   logic [3:0]     dig [N];
   logic [4*N-1:0] chain_q;
   logic           ovr_en  = 1'b0;
   logic [4*N-1:0] ovr_val = '0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!bus.digit_rst)      dig[i] <= 4'd0;
         else if (bus.digit_en[i]) dig[i] <= (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
      end
   end

   always_comb begin
      chain_q = '0;
      for (int i = 0; i < N; i++) chain_q[4*i +: 4] = dig[i];
   end

   assign bus.digit_cnt = ovr_en ? ovr_val : chain_q;

   // Reference model
   mmode_t m_mode     = M_IDLE;
   int     run_cycles = 0;
   bit     m_tick     = 1'b0;
   int     m_val      = 0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4*N-1:0] to_bcd(input int v);
      logic [4*N-1:0] r = '0;
      int x = v;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // One enable for digit 0 plus one per trailing 9 below the top digit.
   function automatic logic [N-1:0] carry_mask(input logic [4*N-1:0] d);
      int k = 1;
      bit go = 1'b1;
      for (int i = 0; i < N-1; i++) begin
         if (go && d[4*i +: 4] == 4'd9) k++;
         else go = 1'b0;
      end
      return N'((1 << k) - 1);
   endfunction

   function automatic bit all_nines(input logic [4*N-1:0] d);
      bit r = 1'b1;
      for (int i = 0; i < N; i++) if (d[4*i +: 4] != 4'd9) r = 1'b0;
      return r;
   endfunction

   task automatic check_outputs();
      bit active, roll, roll_o;
      logic [N-1:0] exp_en;
      active = (m_mode == M_RUN) && m_tick;
      roll   = active && (m_val == MAXV);
      exp_en = !active ? '0 : (SAT_MODE && roll) ? '0 : carry_mask(to_bcd(m_val));
      chk("running",   bus.running,   m_mode == M_RUN);
      chk("tick",      bus.tick,      m_tick);
      chk("digit_en",  bus.digit_en,  exp_en);
      chk("overflow",  bus.overflow,  SAT_MODE ? (m_mode == M_SAT) : roll);
      chk("digit_rst", bus.digit_rst, rst && (m_mode != M_CLR));
      chk("digits",    chain_q,       to_bcd(m_val));
      if (active && $urandom_range(0, 1) == 0) begin
         for (int i = 0; i < N; i++)
            ovr_val[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
         ovr_en = 1'b1;
         #1;
         roll_o = all_nines(ovr_val);
         chk("en_readback", bus.digit_en, (SAT_MODE && roll_o) ? '0 : carry_mask(ovr_val));
         chk("ovf_readback", bus.overflow, !SAT_MODE && roll_o);
         ovr_en = 1'b0;
         #1;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit p, input bit c);
      bit active, roll;
      rst = r; bus.start = s; bus.stop = p; bus.clear = c;
      @(posedge clk);
      active = (m_mode == M_RUN) && m_tick;
      roll   = active && (m_val == MAXV);
      if (!r || m_mode == M_CLR) m_val = 0;
      else if (active && !(SAT_MODE && roll)) m_val = (m_val + 1) % (MAXV + 1);
      if (!r) begin
         m_mode = M_IDLE; run_cycles = 0; m_tick = 1'b0;
      end else begin
         m_tick = 1'b0;
         if (c) begin
            m_mode = M_CLR; run_cycles = 0;
         end else begin
            case (m_mode)
               M_IDLE, M_PAUSE: if (s && !p) m_mode = M_RUN;
               M_RUN: begin
                  if (p) m_mode = M_PAUSE;
                  else if (SAT_MODE && roll) m_mode = M_SAT;
                  else begin
                     run_cycles++;
                     m_tick = (run_cycles % P) == 0;
                  end
               end
               M_CLR:   m_mode = M_IDLE;
               default: ;
            endcase
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (bus.tick !== 1'b1 && n < 3*P) begin
         step(1, 0, 0, 0);
         n++;
      end
      chk("tick_seen", bus.tick, 1'b1);
   endtask

   initial begin
      int n;
      bus.start = 1'b1; bus.stop = 1'b0; bus.clear = 1'b0;
      // Reset with start held
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("rst_digit_rst", bus.digit_rst, 1'b0);
      chk("rst_running",   bus.running,   1'b0);

      // Basic count: ten ticks carry into digit 1
      step(1, 1, 0, 0);
      repeat (41) step(1, 0, 0, 0);
      chk("ten_ticks", chain_q, to_bcd(10));

      // Pause two cycles after a tick, resume, tick comes two cycles later
      wait_tick(n);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      repeat (20) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      wait_tick(n);
      chk("resume_latency", n, 2);

      // Priority: all three in RUN -> CLR then IDLE
      step(1, 1, 1, 1);
      chk("clr_digit_rst", bus.digit_rst, 1'b0);
      step(1, 0, 0, 0);
      chk("clr_digits", chain_q, '0);
      step(1, 1, 0, 0);
      repeat (7) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      step(1, 1, 1, 0);
      chk("pause_start_stop", bus.running, 1'b0);
      repeat (5) step(1, 0, 0, 0);

      // Rollover from a fresh start
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      n = 0;
      while (bus.overflow !== 1'b1 && n < 500) begin
         step(1, 0, 0, 0);
         n++;
      end
`ifdef BCD_CHAIN_CTRL_SATURATE_EN
      chk("ovf_cycle", n, 401);
      chk("sat_digits", chain_q, to_bcd(MAXV));
      repeat (3) step(1, 1, 0, 0);
      chk("sat_hold_ovf", bus.overflow, 1'b1);
      chk("sat_digits_held", chain_q, to_bcd(MAXV));
      step(1, 0, 0, 1);
      chk("sat_clr_ovf", bus.overflow, 1'b0);
      step(1, 0, 0, 0);
      chk("sat_clr_digits", chain_q, '0);
`else
      chk("ovf_cycle", n, 400);
      chk("ovf_en_all", bus.digit_en, {N{1'b1}});
      step(1, 0, 0, 0);
      chk("wrap_digits", chain_q, '0);
      chk("wrap_ovf_pulse", bus.overflow, 1'b0);
      chk("wrap_running", bus.running, 1'b1);
      repeat (10) step(1, 0, 0, 0);
`endif

      // Reset mid-run
      step(1, 0, 0, 1);
      step(1, 1, 0, 0);
      repeat (10) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("midrun_rst_running", bus.running, 1'b0);
      step(1, 0, 0, 0);
      chk("midrun_rst_digits", chain_q, '0);

      // Random command traffic
      repeat (2500) begin
         step($urandom_range(0, 399) != 0,
              $urandom_range(0, 4)   == 0,
              $urandom_range(0, 19)  == 0,
              $urandom_range(0, 59)  == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_chain_ctrl.md
# bcd_chain_ctrl

Run/stop/clear sequencer for a chain of `counter_0_to_9` decade counters forming a multi-digit BCD timer. It divides the system clock into a count tick. It drives each digit's enable with ripple-carry qualification from the digit values it reads back. It issues a synchronous clear to all digits and flags chain overflow. It sits between button/command logic and the `counter_0_to_9` instances.

## Interface
Parameters:
- `NUM_DIGITS`, 2: number of decade counters in the chain; 1..8.
- `PRESCALE`, 10: clk cycles per count tick; ≥2.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: begin or resume counting (level sampled each cycle).
- `stop`  in  1: pause counting.
- `clear`  in  1: zero all digits, return to idle.
- `digit_cnt`  in  4*NUM_DIGITS: readback of digit values; digit 0 (least significant) in bits [3:0].
- `digit_en`  out  NUM_DIGITS: enable to each `counter_0_to_9`.
- `digit_rst`  out  1: active-low synchronous clear to all digits.
- `tick`  out  1: one-cycle prescaler pulse.
- `running`  out  1: high in RUN.
- `overflow`  out  1: one-cycle pulse when the chain rolls over, or held high when saturated (see Configuration).

## Operation
- Each digit counter increments on a clk edge with en=1, wraps from 9 to 0, and clears to 0 on rst=0.
- States:
  - IDLE: digits 0, prescaler 0.
  - RUN: prescaler counting.
  - PAUSE: prescaler and digits frozen.
  - CLR: one cycle, digit_rst=0.
  - SAT: only with the saturate macro.
- Command priority each cycle: clear > stop > start.
- Transitions:
  - clear from any state → CLR → IDLE.
  - IDLE + start → RUN, with the prescaler already 0.
  - RUN + stop → PAUSE.
  - PAUSE + start → RUN, resuming the prescaler from its held value.
  - start+stop together: stop wins; in IDLE this is a no-op.
  - start while in RUN: ignored.
- Prescaler:
  - In RUN, counts 0..PRESCALE-1 and wraps.
  - `tick` is registered: high for the one cycle after the prescaler reaches PRESCALE-1.
- Enables:
  - digit_en[0] = tick & (state==RUN).
  - digit_en[i] = digit_en[i-1] & (digit_cnt[i-1]==9).
  - These are combinational from registered tick and digit_cnt.
- Rollover: all digits are 9 when digit_en[NUM_DIGITS-1] is asserted.
- Digit values above 9 on digit_cnt are treated as not-9 (no carry).
- digit_rst = rst & (state!=CLR), so the digits clear during system reset and in the CLR cycle.

## Timing
- Reset values (rst=0 sampled): state IDLE, prescaler 0, tick 0, digit_en 0, running 0, overflow 0. digit_rst=0 combinationally while rst=0.
- Command latency: command sampled at edge N changes state at edge N; running reflects it the same cycle after the edge.
- First tick: present in the cycle starting PRESCALE edges after entering RUN from IDLE. digit 0 increments on the following edge.
- Stop in the same cycle as tick: tick is already registered, and digit_en is gated by state, so no increment occurs after the stop edge.
- Clear in RUN: no digit increment in the CLR cycle. Next start restarts the full prescale period.
- Rollover: `overflow` pulses in the same cycle as the qualifying digit_en.
- Reset mid-run: behaves exactly as power-on reset.

## Configuration
- `BCD_CHAIN_CTRL_SATURATE_EN`
- Undefined:
  - On rollover, all digits wrap to 0.
  - overflow pulses one cycle.
  - State stays RUN.
- Defined:
  - On a tick that would roll over, all digit_en are suppressed and the chain holds all 9s.
  - State → SAT; overflow and running are held high and low respectively.
  - SAT ignores start/stop; only clear or rst exits, to CLR/IDLE.

## Test plan
- Reset: rst=0 for 2 cycles with start=1 → state IDLE, digit_rst=0, digit_en=0, running=0, overflow=0; digits read 0.
- Basic count (NUM_DIGITS=2, PRESCALE=4): start pulse then 40 cycles → tick every 4 cycles; digits step 00→01…→10 after 10 ticks. digit_en[1] high only on the tick where digit0=9.
- Pause/resume: stop 2 cycles after a tick, hold 20 cycles, then start → digits and prescaler frozen during the pause. The next tick arrives 2 cycles after resume, not 4.
- Priority: start+stop+clear asserted together in RUN → one CLR cycle with digit_rst=0, then IDLE with digits 00. start+stop together in PAUSE → stays PAUSE.
- Rollover, macro undefined: run to 99 → next tick gives digit_en=2'b11 and overflow=1 for one cycle; digits read 00 and counting continues.
- Saturate, macro defined: run to 99 → next tick gives digit_en=0, state SAT, overflow held 1, digits stay 99. start has no effect; clear → CLR then IDLE with digits 00 and overflow 0.
